// File: rtl/seq_tx_001.sv
// seq_tx_001: serial frame transmitter feeding the "001" sequence-detector receive path.
// Frame on tx_out: 0,0,1 sync, DATA_W payload bits MSB first, optional even parity, stop '1', GAP idle '1's.
module seq_tx_001 #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 0,
  parameter int GAP       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [3:0]       LAST_GAP = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PAR,
    STOP,
    GAPW
  } state_t;

  state_t            state,    state_nxt;
  logic [DATA_W-1:0] shreg,    shreg_nxt;
  logic [CNT_W-1:0]  bit_cnt,  bit_cnt_nxt;
  logic [3:0]        gap_cnt,  gap_cnt_nxt;
  logic [1:0]        sync_cnt, sync_cnt_nxt;
  logic              parity,   parity_nxt;
  logic              tx_nxt;
  logic              done_nxt;
  logic              accept;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // tx_out is registered, so each branch computes the level for the state being entered.
  always_comb begin
    // NOTE: every variable driven here gets a default first; no path can leave one unassigned, so no latch.
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    gap_cnt_nxt  = gap_cnt;
    sync_cnt_nxt = sync_cnt;
    parity_nxt   = parity;
    tx_nxt       = 1'b1;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = SYNC;
          shreg_nxt    = in_data;
          parity_nxt   = ^in_data;
          sync_cnt_nxt = 2'd0;
          tx_nxt       = 1'b0;
        end
      end

      SYNC: begin
        case (sync_cnt)
          2'd0: begin
            sync_cnt_nxt = 2'd1;
            tx_nxt       = 1'b0;
          end
          2'd1: begin
            sync_cnt_nxt = 2'd2;
            tx_nxt       = 1'b1;
          end
          default: begin
            state_nxt    = DATA;
            sync_cnt_nxt = 2'd0;
            bit_cnt_nxt  = '0;
            tx_nxt       = shreg[DATA_W-1];
            shreg_nxt    = shreg << 1;
          end
        endcase
      end

      DATA: begin
        if (bit_cnt == LAST_BIT) begin
          if (PARITY_EN != 0) begin
            state_nxt = PAR;
            tx_nxt    = parity;
          end else begin
            state_nxt = STOP;
            done_nxt  = 1'b1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          tx_nxt      = shreg[DATA_W-1];
          shreg_nxt   = shreg << 1;
        end
      end

      PAR: begin
        state_nxt = STOP;
        done_nxt  = 1'b1;
      end

      STOP: begin
        if (GAP > 0) begin
          state_nxt   = GAPW;
          gap_cnt_nxt = 4'd0;
        end else begin
          state_nxt = IDLE;
        end
      end

      GAPW: begin
        if (gap_cnt == LAST_GAP) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: datapath registers are reset too, so an aborted frame leaves no stale payload or parity behind.
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= 4'd0;
      sync_cnt <= 2'd0;
      parity   <= 1'b0;
      tx_out   <= 1'b1;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      sync_cnt <= sync_cnt_nxt;
      parity   <= parity_nxt;
      tx_out   <= tx_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: doc/seq_tx_001.md
Name: seq_tx_001

Overview:
- Serial frame transmitter feeding the "001" sequence-detector receive path.
- Accepts a parallel word over a valid/ready handshake, then shifts out one frame on a single-bit line.
- Frame format: "001" sync preamble, DATA_W payload bits MSB first, optional even-parity bit, a '1' stop bit, then GAP idle '1' cycles.
- The line idles high, so the receiver's detector sees nothing but the sync pattern between frames.

Parameters:
- DATA_W, 8: payload width in bits; legal range 1..32.
- PARITY_EN, 0: when 1, insert an even-parity bit (XOR of the payload) after the payload.
- GAP, 2: number of forced idle '1' cycles after the stop bit; legal range 0..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_W  payload to send.
- in_ready  output  1  block can accept a word; equals (state==IDLE).
- tx_out  output  1  registered serial line; idle level 1.
- busy  output  1  high whenever state!=IDLE.
- done  output  1  one-cycle pulse, high exactly during the stop-bit cycle.

Behaviour:
- Reset values (async on reset=0): state=IDLE, tx_out=1, busy=0, done=0, shift register=0, bit counter=0, gap counter=0, captured parity=0.
- States: IDLE, SYNC, DATA, PAR, STOP, GAPW. State, tx_out and done are registers.
- IDLE:
  - tx_out=1, in_ready=1.
  - Accept on any rising edge where in_valid&&in_ready. At that edge: latch in_data into the shift register, latch parity=^in_data, set sync count=0, go to SYNC.
  - in_data is ignored when not accepted.
- SYNC: three cycles with tx_out=0,0,1. The first 0 becomes visible in the cycle right after the accept edge. After the third cycle, go to DATA.
- DATA:
  - DATA_W cycles; tx_out = shift register MSB; shift left by one each cycle.
  - Bit counter runs 0..DATA_W-1. After the last bit, go to PAR if PARITY_EN=1, else to STOP.
- PAR: one cycle, tx_out = latched parity.
- STOP: one cycle, tx_out=1 and done=1. Then go to GAPW if GAP>0, else to IDLE.
- GAPW: GAP cycles with tx_out=1, then IDLE.
- Latency: first sync bit appears 1 cycle after the accept edge.
- Frame length in cycles = 3 + DATA_W + PARITY_EN + 1 + GAP.
- in_ready and busy are complements, both derived from the registered state. No word is accepted while busy; in_valid held high while busy is ignored and does not stall or corrupt the frame.
- Back-to-back frames:
  - With in_valid held high, the next word is accepted on the first IDLE cycle.
  - Minimum spacing between the stop bit and the next sync bit = GAP+1 cycles of line-high (the IDLE accept cycle included).
- Simultaneous events: an accept edge and the IDLE entry never coincide. Entry into IDLE occurs on the edge that leaves STOP/GAPW; acceptance happens on a later edge.
- Counters are sized for their maximum count: clog2(DATA_W) bits for the bit counter, 4 bits for the gap counter. No wrap-around is observable.
- Reset mid-frame:
  - Immediate abort: tx_out=1, state=IDLE, no done pulse; the partial frame is discarded.
  - A reset during the two sync zeros produces "00" then "1" on the line, which the receiver may flag. This is accepted system behaviour; software resynchronises.
- A payload containing "001" is not escaped. The receiver ignores its detector while a frame is in progress.

Test Plan:
- Reset release with in_valid=0 → tx_out=1, in_ready=1, busy=0, done=0 held for 20 cycles.
- DATA_W=8, PARITY_EN=0, GAP=2, send 8'hA5 → tx_out = 0,0,1,1,0,1,0,0,1,0,1,1,1,1 starting 1 cycle after accept. done high only on the 12th bit (stop). in_ready returns high 14 cycles after accept.
- PARITY_EN=1, send 8'hA5 then 8'h07 back-to-back with in_valid held → parity bits 0 then 1. Second sync starts after exactly 3 line-high cycles following the first stop bit. Exactly 2 done pulses.
- in_valid toggled with different in_data (8'hFF, 8'h00) while busy mid-frame sending 8'h3C → line carries exactly 0,0,1,0,0,1,1,1,1,0,0 then stop. No extra word accepted.
- Assert reset=0 asynchronously (between clock edges) during DATA bit 4 → tx_out=1 before the next clock edge, busy=0. After release, sending 8'h81 produces a clean, complete frame.
- GAP=0, DATA_W=1, send 1'b1 → line 0,0,1,1,1 then IDLE. Next accept possible 1 cycle after the stop bit.
